// File: rtl/vid_mem_resp.sv
// vid_mem_resp: bus target modelling a pixel/frame-buffer memory.
// Serves burst reads (data beats back to the initiator after a bid/grant
// handshake) and burst writes (data beats in, one-cycle write response out).
// A backdoor load port lets a bench place frame data anywhere in the array.
module vid_mem_resp #(
  parameter int MEM_WORDS = 256,
  parameter int RD_LAT    = 2
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic                         selin,
  input  logic [2:0]                   cmdin,
  input  logic [1:0]                   lenin,
  input  logic [31:0]                  addrdatain,
  input  logic                         gntin,
  input  logic                         ld_we,
  input  logic [$clog2(MEM_WORDS)-1:0] ld_addr,
  input  logic [31:0]                  ld_data,
  output logic [1:0]                   reqout,
  output logic [2:0]                   cmdout,
  output logic [1:0]                   lenout,
  output logic [31:0]                  addrdataout,
  output logic                         busy
);

  localparam int AW = $clog2(MEM_WORDS);
  localparam logic [AW-1:0] IDX_ONE = 1;

  localparam logic [2:0] CMD_IDLE   = 3'b000;
  localparam logic [2:0] CMD_RD     = 3'b010;
  localparam logic [2:0] CMD_WR     = 3'b100;
  localparam logic [2:0] CMD_MORE   = 3'b011;
  localparam logic [2:0] CMD_LAST   = 3'b001;
  localparam logic [2:0] CMD_WRRESP = 3'b101;

  typedef enum logic [2:0] {
    IDLE,
    RD_WAIT,
    RD_BID,
    RD_DATA,
    WR_DATA,
    WR_RESP
  } state_t;

  state_t        state_reg, state_next;
  logic [AW-1:0] idx_reg, idx_next;
  logic [1:0]    len_reg, len_next;
  logic [3:0]    cnt_reg, cnt_next;
  logic [2:0]    beat_reg, beat_next;
  logic [1:0]    reqout_reg, reqout_next;
  logic [2:0]    cmdout_reg, cmdout_next;
  logic [1:0]    lenout_reg, lenout_next;
  logic [31:0]   data_reg;
  logic          busy_reg;
  logic          rd_beat;
  logic          wr_en;

  // Beat count is 1 << len; the index of the final beat is that minus one
  // (the 3-bit wrap turns 8 into 0, so 0 - 1 gives 7 for len code 11).
  logic [3:0] n_beats;
  logic [2:0] last_beat;
  assign n_beats   = 4'd1 << len_reg;
  assign last_beat = n_beats[2:0] - 3'd1;

  logic [31:0] mem [MEM_WORDS];

  // Next-state and next-output decode. Outputs are computed one cycle ahead
  // so that every port is driven straight from a flop.
  always_comb begin
    state_next  = state_reg;
    idx_next    = idx_reg;
    len_next    = len_reg;
    cnt_next    = cnt_reg;
    beat_next   = beat_reg;
    reqout_next = 2'b00;
    cmdout_next = CMD_IDLE;
    lenout_next = 2'b00;
    rd_beat     = 1'b0;
    wr_en       = 1'b0;
    case (state_reg)
      IDLE: begin
        if (selin && cmdin == CMD_RD) begin
          idx_next  = addrdatain[AW+1:2];
          len_next  = lenin;
          beat_next = 3'd0;
          cnt_next  = 4'(RD_LAT);
          if (RD_LAT == 0) begin
            state_next  = RD_BID;
            reqout_next = 2'b11;
          end else begin
            state_next = RD_WAIT;
          end
        end else if (selin && cmdin == CMD_WR) begin
          idx_next   = addrdatain[AW+1:2];
          len_next   = lenin;
          beat_next  = 3'd0;
          state_next = WR_DATA;
        end
      end
      RD_WAIT: begin
        // The counter reaches zero on this edge when it currently reads one.
        cnt_next = cnt_reg - 4'd1;
        if (cnt_reg == 4'd1) begin
          state_next  = RD_BID;
          reqout_next = 2'b11;
        end
      end
      RD_BID, RD_DATA: begin
        // A sampled grant immediately produces a beat, so the first beat
        // shows up RD_LAT+1 edges after acceptance.
        reqout_next = 2'b11;
        if (gntin) begin
          rd_beat     = 1'b1;
          lenout_next = len_reg;
          idx_next    = idx_reg + IDX_ONE;
          beat_next   = beat_reg + 3'd1;
          if (beat_reg == last_beat) begin
            cmdout_next = CMD_LAST;
            state_next  = IDLE;
          end else begin
            cmdout_next = CMD_MORE;
            state_next  = RD_DATA;
          end
        end
      end
      WR_DATA: begin
        if (cmdin == CMD_MORE || cmdin == CMD_LAST) begin
          wr_en     = 1'b1;
          idx_next  = idx_reg + IDX_ONE;
          beat_next = beat_reg + 3'd1;
          if (cmdin == CMD_LAST || beat_reg == last_beat) begin
            state_next  = WR_RESP;
            reqout_next = 2'b11;
            cmdout_next = CMD_WRRESP;
          end
        end
      end
      WR_RESP: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // State, burst bookkeeping and registered control outputs.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_reg  <= IDLE;
      idx_reg    <= '0;
      len_reg    <= 2'b00;
      cnt_reg    <= 4'd0;
      beat_reg   <= 3'd0;
      reqout_reg <= 2'b00;
      cmdout_reg <= CMD_IDLE;
      lenout_reg <= 2'b00;
      busy_reg   <= 1'b0;
    end else begin
      state_reg  <= state_next;
      idx_reg    <= idx_next;
      len_reg    <= len_next;
      cnt_reg    <= cnt_next;
      beat_reg   <= beat_next;
      reqout_reg <= reqout_next;
      cmdout_reg <= cmdout_next;
      lenout_reg <= lenout_next;
      busy_reg   <= (state_next != IDLE);
    end
  end

  // Registered memory read; the bus is zero whenever no beat is driven.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      data_reg <= 32'd0;
    end else if (rd_beat) begin
      data_reg <= mem[idx_reg];
    end else begin
      data_reg <= 32'd0;
    end
  end

  // Memory writes. The backdoor assignment comes last so it wins a same-word
  // collision; contents are deliberately untouched by reset.
  always_ff @(posedge clk) begin
    if (wr_en && reset_n) begin
      mem[idx_reg] <= addrdatain;
    end
    if (ld_we) begin
      mem[ld_addr] <= ld_data;
    end
  end

  assign reqout      = reqout_reg;
  assign cmdout      = cmdout_reg;
  assign lenout      = lenout_reg;
  assign addrdataout = data_reg;
  assign busy        = busy_reg;

endmodule

// File: tb/tb_vid_mem_resp.sv
// tb_vid_mem_resp: directed plus randomized bursts against vid_mem_resp.
// The reference is a plain word array updated by every backdoor load and bus
// write; each expected beat and response is derived from the bus rules.
module tb_vid_mem_resp;

  localparam int MEM_WORDS = 256;
  localparam int RD_LAT    = 2;
  localparam int AW        = 8;

  logic          clk;
  logic          reset_n;
  logic          selin;
  logic [2:0]    cmdin;
  logic [1:0]    lenin;
  logic [31:0]   addrdatain;
  logic          gntin;
  logic          ld_we;
  logic [AW-1:0] ld_addr;
  logic [31:0]   ld_data;
  logic [1:0]    reqout;
  logic [2:0]    cmdout;
  logic [1:0]    lenout;
  logic [31:0]   addrdataout;
  logic          busy;

  int vectors = 0;
  int miscompares = 0;

  logic [31:0] model_mem [MEM_WORDS];

  vid_mem_resp #(
    .MEM_WORDS(MEM_WORDS),
    .RD_LAT   (RD_LAT)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .selin      (selin),
    .cmdin      (cmdin),
    .lenin      (lenin),
    .addrdatain (addrdatain),
    .gntin      (gntin),
    .ld_we      (ld_we),
    .ld_addr    (ld_addr),
    .ld_data    (ld_data),
    .reqout     (reqout),
    .cmdout     (cmdout),
    .lenout     (lenout),
    .addrdataout(addrdataout),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic ld(input int a, input logic [31:0] d);
    ld_we   = 1'b1;
    ld_addr = a[AW-1:0];
    ld_data = d;
    tick();
    ld_we = 1'b0;
    model_mem[a] = d;
    $display("load   mem[%0d] = 0x%08h", a, d);
  endtask

  // Read burst; optional grant stall before beat stall_at, optional backdoor
  // write to the word being read at beat ld_at, optional ignored second request.
  task automatic do_read(input logic [31:0] addr, input logic [1:0] len, input int stall_at,
                         input int stall_len, input int ld_at, input bit dup_req);
    int n;
    int base;
    int idx;
    logic [31:0] exp;
    n    = 1 << len;
    base = int'(addr[AW+1:2]);
    selin = 1'b1; cmdin = 3'b010; lenin = len; addrdatain = addr; gntin = 1'b1;
    tick();
    selin = 1'b0; cmdin = 3'b000; addrdatain = $urandom;
    check("rd_accept_busy", 32'(busy), 32'd1);
    for (int k = 1; k <= RD_LAT; k++) begin
      if (dup_req && k == 1) begin
        selin = 1'b1; cmdin = 3'b010; lenin = 2'b00; addrdatain = addr + 32'h100;
      end
      tick();
      selin = 1'b0; cmdin = 3'b000;
      check("rd_wait_cmd", 32'(cmdout), 32'd0);
      check("rd_wait_req", 32'(reqout), (k == RD_LAT) ? 32'd3 : 32'd0);
      check("rd_wait_busy", 32'(busy), 32'd1);
    end
    for (int b = 0; b < n; b++) begin
      idx = (base + b) % MEM_WORDS;
      if (b == stall_at) begin
        gntin = 1'b0;
        for (int s = 0; s < stall_len; s++) begin
          tick();
          check("stall_cmd", 32'(cmdout), 32'd0);
          check("stall_data", addrdataout, 32'd0);
          check("stall_req", 32'(reqout), 32'd3);
        end
        gntin = 1'b1;
      end
      exp = model_mem[idx];
      if (b == ld_at) begin
        ld_we = 1'b1; ld_addr = idx[AW-1:0]; ld_data = ~exp;
      end
      tick();
      ld_we = 1'b0;
      if (b == ld_at) model_mem[idx] = ~exp;
      check("beat_data", addrdataout, exp);
      check("beat_cmd", 32'(cmdout), (b == n - 1) ? 32'd1 : 32'd3);
      check("beat_len", 32'(lenout), 32'(len));
      check("beat_req", 32'(reqout), 32'd3);
      $display("read   beat %0d idx %0d data 0x%08h cmd %03b", b, idx, addrdataout, cmdout);
    end
    tick();
    check("rd_end_req", 32'(reqout), 32'd0);
    check("rd_end_cmd", 32'(cmdout), 32'd0);
    check("rd_end_busy", 32'(busy), 32'd0);
    if (dup_req) begin
      for (int k = 0; k < RD_LAT + 4; k++) begin
        tick();
        check("dup_ignored_cmd", 32'(cmdout), 32'd0);
        check("dup_ignored_req", 32'(reqout), 32'd0);
      end
    end
  endtask

  // Write burst of nbeats beats; the last carries 001 when last_flag is set,
  // an idle cycle precedes beat idle_at, and beat collide_at also sees a
  // backdoor write to the same word.
  task automatic do_write(input logic [31:0] addr, input logic [1:0] len, input int nbeats,
                          input bit last_flag, input int idle_at, input int collide_at,
                          input bit use_fixed, input logic [31:0] fixed_base);
    int n;
    int base;
    int idx;
    logic [31:0] d;
    n    = 1 << len;
    base = int'(addr[AW+1:2]);
    selin = 1'b1; cmdin = 3'b100; lenin = len; addrdatain = addr;
    tick();
    selin = 1'b0; cmdin = 3'b000;
    check("wr_accept_busy", 32'(busy), 32'd1);
    for (int b = 0; b < nbeats; b++) begin
      idx = (base + b) % MEM_WORDS;
      if (b == idle_at) begin
        cmdin = 3'b000; addrdatain = $urandom;
        tick();
        check("wr_idle_cmd", 32'(cmdout), 32'd0);
        check("wr_idle_busy", 32'(busy), 32'd1);
      end
      d = use_fixed ? fixed_base + 32'(b) : $urandom;
      addrdatain = d;
      cmdin = (b == nbeats - 1 && last_flag) ? 3'b001 : 3'b011;
      if (b == collide_at) begin
        ld_we = 1'b1; ld_addr = idx[AW-1:0]; ld_data = ~d;
      end
      tick();
      ld_we = 1'b0;
      model_mem[idx] = (b == collide_at) ? ~d : d;
      $display("write  beat %0d idx %0d data 0x%08h", b, idx, model_mem[idx]);
      if (b != nbeats - 1) check("wr_mid_cmd", 32'(cmdout), 32'd0);
    end
    // One surplus beat after the burst must be ignored.
    cmdin = 3'b011; addrdatain = $urandom;
    check("wr_resp_cmd", 32'(cmdout), 32'd5);
    check("wr_resp_req", 32'(reqout), 32'd3);
    check("wr_resp_busy", 32'(busy), 32'd1);
    tick();
    cmdin = 3'b000;
    check("wr_after_cmd", 32'(cmdout), 32'd0);
    check("wr_after_req", 32'(reqout), 32'd0);
    check("wr_after_busy", 32'(busy), 32'd0);
  endtask

  initial begin
    int n;
    int nb;
    bit lf;
    logic [31:0] a;
    logic [1:0] l;
    reset_n = 1'b0; selin = 1'b0; cmdin = 3'b000; lenin = 2'b00; addrdatain = 32'd0;
    gntin = 1'b0; ld_we = 1'b0; ld_addr = '0; ld_data = 32'd0;
    tick();
    tick();
    check("rst_req", 32'(reqout), 32'd0);
    check("rst_cmd", 32'(cmdout), 32'd0);
    check("rst_len", 32'(lenout), 32'd0);
    check("rst_data", addrdataout, 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    reset_n = 1'b1;
    tick();

    for (int i = 0; i < MEM_WORDS; i++) ld(i, $urandom);

    // Four-beat read of preloaded words.
    ld(0, 32'h00112233); ld(1, 32'h00445566); ld(2, 32'h00778899); ld(3, 32'h00AABBCC);
    do_read(32'h0, 2'b10, -1, 0, -1, 1'b0);

    // Wrap from the top word back to word 0.
    ld(255, 32'h000000FF); ld(0, 32'h00000001);
    do_read(32'h3FC, 2'b01, -1, 0, -1, 1'b0);

    // Write with an idle cycle mid-burst, then read it back.
    do_write(32'h40, 2'b10, 4, 1'b1, 2, -1, 1'b1, 32'hA);
    do_read(32'h40, 2'b10, -1, 0, -1, 1'b0);

    // Eight-beat read with a three-cycle grant stall before beat 4.
    do_read(32'h80, 2'b11, 3, 3, -1, 1'b0);

    // Second request during the latency wait is ignored.
    do_read(32'h10, 2'b10, -1, 0, -1, 1'b1);

    // Reset in the middle of a four-beat read.
    ld(0, 32'h00112233);
    selin = 1'b1; cmdin = 3'b010; lenin = 2'b10; addrdatain = 32'h0; gntin = 1'b1;
    tick();
    selin = 1'b0; cmdin = 3'b000;
    for (int k = 0; k < RD_LAT; k++) tick();
    tick();
    check("mid_beat1", addrdataout, model_mem[0]);
    tick();
    check("mid_beat2", addrdataout, model_mem[1]);
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    check("mid_rst_req", 32'(reqout), 32'd0);
    check("mid_rst_cmd", 32'(cmdout), 32'd0);
    check("mid_rst_len", 32'(lenout), 32'd0);
    check("mid_rst_data", addrdataout, 32'd0);
    check("mid_rst_busy", 32'(busy), 32'd0);
    $display("reset  asserted mid-burst");
    for (int k = 0; k < 3; k++) begin
      tick();
      check("mid_rst_dropped", 32'(cmdout), 32'd0);
    end
    do_read(32'h0, 2'b10, -1, 0, -1, 1'b0);

    // Backdoor wins a same-word collision; read returns the pre-write word.
    do_write(32'h100, 2'b01, 2, 1'b1, -1, 1, 1'b0, 32'd0);
    do_read(32'h100, 2'b01, -1, 0, -1, 1'b0);
    do_read(32'h200, 2'b00, -1, 0, 0, 1'b0);
    do_read(32'h200, 2'b00, -1, 0, -1, 1'b0);

    // Randomized bursts.
    for (int it = 0; it < 30; it++) begin
      a = $urandom;
      l = 2'($urandom_range(0, 3));
      n = 1 << l;
      if ($urandom_range(0, 1) == 0) begin
        do_read(a, l, $urandom_range(0, n), $urandom_range(1, 3),
                ($urandom_range(0, 3) == 0) ? $urandom_range(0, n - 1) : -1, 1'b0);
      end else begin
        nb = $urandom_range(1, n);
        lf = (nb < n) ? 1'b1 : 1'($urandom_range(0, 1));
        do_write(a, l, nb, lf, $urandom_range(0, nb),
                 ($urandom_range(0, 3) == 0) ? $urandom_range(0, nb - 1) : -1, 1'b0, 32'd0);
        do_read(a, l, -1, 0, -1, 1'b0);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
